// File: rtl/noc_router_route_lookup_pkg.sv
// Shared types and helpers for the per-input-port route lookup stage.
// Holds the worm-tracking state enum, the destination extractor and the default route entry.
package noc_router_pkg;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } route_state_t;

    localparam int unsigned MAX_FLIT_WIDTH = 256;
    localparam int unsigned MAX_DEST_WIDTH = 16;

    // Entry value used for every destination when no table is supplied: output 0 only.
    localparam int unsigned DEFAULT_ROUTE_ENTRY = 1;

    // Destination lives in the top dest_width bits of the flit; result is zero-extended.
    function automatic logic [MAX_DEST_WIDTH-1:0] extract_dest(
        input logic [MAX_FLIT_WIDTH-1:0] flit,
        input int unsigned               flit_width,
        input int unsigned               dest_width
    );
        logic [MAX_DEST_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DEST_WIDTH; i++) begin
            mask[i] = (i < dest_width) ? 1'b1 : 1'b0;
        end
        return MAX_DEST_WIDTH'(flit >> (flit_width - dest_width)) & mask;
    endfunction

endpackage

// File: rtl/noc_router_route_table.sv
// Combinational destination-to-route map; a hit needs an in-range dest and a non-zero entry.
module noc_router_route_table
    import noc_router_pkg::*;
#(
    parameter int unsigned OUTPUTS = 7,
    parameter int unsigned DESTS   = 8,
    parameter logic [DESTS*OUTPUTS-1:0] ROUTES = {DESTS{OUTPUTS'(DEFAULT_ROUTE_ENTRY)}}
) (
    input  logic [MAX_DEST_WIDTH-1:0] dest,
    output logic                      hit,
    output logic [OUTPUTS-1:0]        entry
);

    logic in_range_s;

    // Table select and routability decision.
    always_comb begin
        entry = '0;
        for (int d = 0; d < DESTS; d++) begin
            entry = (dest == MAX_DEST_WIDTH'(d)) ? ROUTES[d*OUTPUTS +: OUTPUTS] : entry;
        end
        in_range_s = (dest < MAX_DEST_WIDTH'(DESTS));
        hit        = in_range_s & (|entry);
    end

endmodule

// File: rtl/noc_router_route_lookup.sv
// Per-input-port routing stage: decodes the header, holds the route for the worm,
// discards unroutable packets and feeds the lookup slice through one register stage.
module noc_router_route_lookup
    import noc_router_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned OUTPUTS    = 7,
    parameter int unsigned DESTS      = 8,
    parameter int unsigned DEST_WIDTH = 5,
    parameter logic [DESTS*OUTPUTS-1:0] ROUTES = {DESTS{OUTPUTS'(DEFAULT_ROUTE_ENTRY)}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic [OUTPUTS-1:0]    out_valid,
    input  logic                  out_ready,
    output logic                  drop_pkt
);

    route_state_t              state_r;
    route_state_t              state_nxt_s;
    logic [OUTPUTS-1:0]        route_r;
    logic [OUTPUTS-1:0]        route_nxt_s;
    logic [OUTPUTS-1:0]        load_route_s;
    logic                      load_s;
    logic                      drop_nxt_s;
    logic                      accept_s;
    logic [MAX_DEST_WIDTH-1:0] dest_s;
    logic                      hit_s;
    logic [OUTPUTS-1:0]        entry_s;

    assign dest_s   = extract_dest(MAX_FLIT_WIDTH'(in_flit), FLIT_WIDTH, DEST_WIDTH);
    assign in_ready = (state_r == DROP) | ~(|out_valid) | out_ready;
    assign accept_s = in_valid & in_ready;

    noc_router_route_table #(
        .OUTPUTS (OUTPUTS),
        .DESTS   (DESTS),
        .ROUTES  (ROUTES)
    ) u_route_table (
        .dest  (dest_s),
        .hit   (hit_s),
        .entry (entry_s)
    );

    // Worm FSM next state, route capture and output-register load decision.
    always_comb begin
        state_nxt_s  = state_r;
        route_nxt_s  = route_r;
        load_route_s = route_r;
        load_s       = 1'b0;
        drop_nxt_s   = 1'b0;
        case (state_r)
            HEAD: begin
                if (accept_s) begin
                    if (hit_s) begin
                        load_s       = 1'b1;
                        load_route_s = entry_s;
                        route_nxt_s  = entry_s;
                        state_nxt_s  = in_last ? HEAD : BODY;
                    end else begin
                        drop_nxt_s  = 1'b1;
                        state_nxt_s = in_last ? HEAD : DROP;
                    end
                end else begin
                    state_nxt_s = HEAD;
                end
            end
            BODY: begin
                if (accept_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = in_last ? HEAD : BODY;
                end else begin
                    state_nxt_s = BODY;
                end
            end
            DROP: begin
                if (accept_s && in_last) begin
                    state_nxt_s = HEAD;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: begin
                state_nxt_s = HEAD;
            end
        endcase
    end

    // Control state, held route, drop pulse and route-valid vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= HEAD;
            route_r   <= '0;
            drop_pkt  <= 1'b0;
            out_valid <= '0;
        end else begin
            state_r  <= state_nxt_s;
            route_r  <= route_nxt_s;
            drop_pkt <= drop_nxt_s;
            if (load_s) begin
                out_valid <= load_route_s;
            end else if (out_ready && (|out_valid)) begin
                out_valid <= '0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

    // Payload half of the output register; qualified by out_valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_s) begin
            out_flit <= in_flit;
            out_last <= in_last;
        end else begin
            out_flit <= out_flit;
            out_last <= out_last;
        end
    end

endmodule
